// File: rtl/cache_line_write_merger.sv
// cache_line_write_merger: write-combining buffer between the store path and
// a line-wide write port. Byte-masked word writes to one line are merged into
// a single image + strobe, which is emitted on full, miss, flush or idle timeout.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_EMPTY   | no line buffered; any write may start a new line
// S_MERGING | line buffered; hit writes merge, idle counter runs
// S_DRAIN   | line presented on line_valid until line_ready handshake
module cache_line_write_merger #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    p_req_valid,
  output logic                                    p_req_ready,
  input  logic [ADDR_WIDTH-1:0]                   p_addr,
  input  logic [WORD_WIDTH/8-1:0]                 p_w_en,
  input  logic [WORD_WIDTH-1:0]                   p_wdata,
  input  logic                                    flush,
  output logic                                    line_valid,
  input  logic                                    line_ready,
  output logic [ADDR_WIDTH-1:0]                   line_addr,
  output logic [WORD_WIDTH*WORDS_PER_LINE-1:0]    line_data,
  output logic [WORD_WIDTH/8*WORDS_PER_LINE-1:0]  line_strb,
  output logic                                    buf_empty
);

  localparam int BPW    = WORD_WIDTH / 8;
  localparam int BO     = $clog2(BPW);
  localparam int WO     = $clog2(WORDS_PER_LINE);
  localparam int LO     = BO + WO;
  localparam int TAG_W  = ADDR_WIDTH - LO;
  localparam int LINE_W = WORD_WIDTH * WORDS_PER_LINE;
  localparam int STRB_W = BPW * WORDS_PER_LINE;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_MERGING,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [TAG_W-1:0]  tag_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [WO-1:0]     word_off;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              accept;
  logic              timeout_hit;
  logic [31:0]       shift_data;
  logic [31:0]       shift_strb;
  logic [LINE_W-1:0] wdata_sh;
  logic [STRB_W-1:0] wen_sh;
  logic [LINE_W-1:0] base_data;
  logic [STRB_W-1:0] base_strb;
  logic [LINE_W-1:0] merged_data;
  logic [STRB_W-1:0] merged_strb;

  // Byte-offset address bits carry no information for word writes.
  if (BO > 0) begin : g_unused
    logic unused_byte_off;
    assign unused_byte_off = ^p_addr[BO-1:0];
  end

  assign word_off    = p_addr[LO-1:BO];
  assign req_tag     = p_addr[ADDR_WIDTH-1:LO];
  assign hit         = (req_tag == tag_q);
  assign shift_data  = 32'(word_off) * 32'(WORD_WIDTH);
  assign shift_strb  = 32'(word_off) * 32'(BPW);
  assign line_addr   = {tag_q, {LO{1'b0}}};
  assign accept      = p_req_valid && p_req_ready;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Ready: a miss in MERGING stalls the processor until the old line drains.
  always_comb begin
    case (state)
      S_EMPTY:   p_req_ready = 1'b1;
      S_MERGING: p_req_ready = !(p_req_valid && !hit);
      default:   p_req_ready = 1'b0;
    endcase
  end

  // Merge the incoming word into the buffered image (a cleared image when EMPTY).
  always_comb begin
    wdata_sh    = LINE_W'(p_wdata) << shift_data;
    wen_sh      = STRB_W'(p_w_en) << shift_strb;
    base_data   = (state == S_EMPTY) ? '0 : line_data;
    base_strb   = (state == S_EMPTY) ? '0 : line_strb;
    merged_data = base_data;
    for (int i = 0; i < STRB_W; i++) begin
      if (wen_sh[i]) merged_data[i*8 +: 8] = wdata_sh[i*8 +: 8];
    end
    merged_strb = base_strb | wen_sh;
  end

  // Buffer FSM; line image/strobe registers double as the line outputs, and
  // bytes are only ever written together with their strobe, so unstrobed bytes stay 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      tag_q      <= '0;
      cnt_q      <= '0;
      line_data  <= '0;
      line_strb  <= '0;
      line_valid <= 1'b0;
      buf_empty  <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept && (|p_w_en)) begin
            tag_q     <= req_tag;
            line_data <= merged_data;
            line_strb <= merged_strb;
            cnt_q     <= '0;
            state     <= S_MERGING;
            buf_empty <= 1'b0;
          end
        end
        S_MERGING: begin
          if (accept) begin
            line_data <= merged_data;
            line_strb <= merged_strb;
            cnt_q     <= '0;
            if ((&merged_strb) || flush) begin
              state      <= S_DRAIN;
              line_valid <= 1'b1;
            end
          end else if (flush || p_req_valid || timeout_hit) begin
            // p_req_valid without accept here is a miss
            state      <= S_DRAIN;
            line_valid <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (line_ready) begin
            state      <= S_EMPTY;
            line_valid <= 1'b0;
            buf_empty  <= 1'b1;
            line_data  <= '0;
            line_strb  <= '0;
            cnt_q      <= '0;
          end
        end
        default: begin
          state      <= S_EMPTY;
          line_valid <= 1'b0;
          buf_empty  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_write_merger.sv
// Bench for cache_line_write_merger: directed scenarios on a default instance,
// timeout behaviour on TIMEOUT=8 and TIMEOUT=0 instances, then randomized
// traffic on the default instance against a byte-array reference model.
module tb_cache_line_write_merger;

  localparam int AW  = 32;
  localparam int WW  = 32;
  localparam int BPW = 4;
  localparam int LW  = 128;
  localparam int SW  = 16;
  localparam int TO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [AW-1:0]  p_addr;
  logic [BPW-1:0] p_w_en;
  logic [WW-1:0]  p_wdata;
  logic           flush;
  logic           line_ready;

  logic           p_req_valid, p_req_ready, line_valid, buf_empty;
  logic [AW-1:0]  line_addr;
  logic [LW-1:0]  line_data;
  logic [SW-1:0]  line_strb;

  logic           valid_t8, ready_t8, lv_t8, empty_t8;
  logic [AW-1:0]  addr_t8;
  logic [LW-1:0]  data_t8;
  logic [SW-1:0]  strb_t8;

  logic           valid_t0, ready_t0, lv_t0, empty_t0;
  logic [AW-1:0]  addr_t0;
  logic [LW-1:0]  data_t0;
  logic [SW-1:0]  strb_t0;

  cache_line_write_merger dut (
    .clk(clk), .rst_n(rst_n), .p_req_valid(p_req_valid), .p_req_ready(p_req_ready),
    .p_addr(p_addr), .p_w_en(p_w_en), .p_wdata(p_wdata), .flush(flush),
    .line_valid(line_valid), .line_ready(line_ready), .line_addr(line_addr),
    .line_data(line_data), .line_strb(line_strb), .buf_empty(buf_empty)
  );

  cache_line_write_merger #(.TIMEOUT(8)) dut_t8 (
    .clk(clk), .rst_n(rst_n), .p_req_valid(valid_t8), .p_req_ready(ready_t8),
    .p_addr(p_addr), .p_w_en(p_w_en), .p_wdata(p_wdata), .flush(flush),
    .line_valid(lv_t8), .line_ready(line_ready), .line_addr(addr_t8),
    .line_data(data_t8), .line_strb(strb_t8), .buf_empty(empty_t8)
  );

  cache_line_write_merger #(.TIMEOUT(0)) dut_t0 (
    .clk(clk), .rst_n(rst_n), .p_req_valid(valid_t0), .p_req_ready(ready_t0),
    .p_addr(p_addr), .p_w_en(p_w_en), .p_wdata(p_wdata), .flush(flush),
    .line_valid(lv_t0), .line_ready(line_ready), .line_addr(addr_t0),
    .line_data(data_t0), .line_strb(strb_t0), .buf_empty(empty_t0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: "a line is buffered", "the line is being offered",
  // its line number, per-byte contents/valid flags and cycles since the last write.
  bit          m_busy, m_out;
  int unsigned m_tag, m_idle;
  logic [7:0]  m_byte [SW];
  bit          m_st   [SW];

  task automatic model_clear();
    for (int i = 0; i < SW; i++) begin
      m_byte[i] = 8'h00;
      m_st[i]   = 1'b0;
    end
  endtask

  task automatic model_merge(input int unsigned word);
    for (int b = 0; b < BPW; b++) begin
      if (p_w_en[b]) begin
        m_byte[word*BPW + b] = p_wdata[b*8 +: 8];
        m_st[word*BPW + b]   = 1'b1;
      end
    end
  endtask

  function automatic bit model_full();
    bit f = 1'b1;
    for (int i = 0; i < SW; i++) f = f & m_st[i];
    return f;
  endfunction

  function automatic logic [LW-1:0] model_data();
    logic [LW-1:0] d = '0;
    for (int i = 0; i < SW; i++) if (m_st[i]) d[i*8 +: 8] = m_byte[i];
    return d;
  endfunction

  function automatic logic [SW-1:0] model_strb();
    logic [SW-1:0] s = '0;
    for (int i = 0; i < SW; i++) s[i] = m_st[i];
    return s;
  endfunction

  function automatic bit model_ready();
    return !m_out && !(m_busy && p_req_valid && ((p_addr >> 4) != m_tag));
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step(input bit rdy);
    int unsigned tag, word;
    bit acc;
    tag  = p_addr >> 4;
    word = (p_addr >> 2) & 32'd3;
    acc  = p_req_valid && rdy;
    if (m_out) begin
      if (line_ready) begin
        m_out  = 1'b0;
        m_busy = 1'b0;
        model_clear();
      end
    end else if (!m_busy) begin
      if (acc && p_w_en != 0) begin
        m_busy = 1'b1;
        m_tag  = tag;
        model_clear();
        model_merge(word);
        m_idle = 0;
      end
    end else if (acc) begin
      model_merge(word);
      m_idle = 0;
      if (model_full() || flush) m_out = 1'b1;
    end else if (flush || p_req_valid) begin
      m_out = 1'b1;
    end else begin
      m_idle++;
      if (TO != 0 && m_idle == TO) m_out = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    p_req_valid = 1'b0;
    valid_t8    = 1'b0;
    valid_t0    = 1'b0;
    flush       = 1'b0;
    line_ready  = 1'b0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [BPW-1:0] e, input logic [WW-1:0] d);
    p_req_valid = 1'b1;
    p_addr      = a;
    p_w_en      = e;
    p_wdata     = d;
  endtask

  initial begin
    bit hold, quiet, exp_rdy;

    // reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_req_valid = 1'($urandom);
      valid_t8    = 1'($urandom);
      valid_t0    = 1'($urandom);
      p_addr      = $urandom;
      p_w_en      = 4'($urandom);
      p_wdata     = $urandom;
      flush       = 1'($urandom);
      line_ready  = 1'($urandom);
      @(negedge clk);
    end
    #1;
    check_val("rst_valid", line_valid, 1'b0);
    check_val("rst_strb", line_strb, 16'h0);
    check_val("rst_data", line_data, 128'h0);
    check_val("rst_addr", line_addr, 32'h0);
    check_val("rst_empty", buf_empty, 1'b1);
    check_val("rst_ready", p_req_ready, 1'b1);
    check_val("rst_t8_valid", lv_t8, 1'b0);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_empty", buf_empty, 1'b1);
    check_val("post_rst_ready", p_req_ready, 1'b1);

    // single write plus flush
    drive_write(32'h100, 4'hF, 32'hAABBCCDD);
    @(negedge clk);
    check_val("t1_not_empty", buf_empty, 1'b0);
    check_val("t1_no_valid", line_valid, 1'b0);
    p_req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check_val("t1_valid", line_valid, 1'b1);
    check_val("t1_addr", line_addr, 32'h100);
    check_val("t1_strb", line_strb, 16'h000F);
    check_val("t1_data", line_data, {96'h0, 32'hAABBCCDD});
    flush = 1'b0;
    line_ready = 1'b1;
    @(negedge clk);
    check_val("t1_done_valid", line_valid, 1'b0);
    check_val("t1_done_empty", buf_empty, 1'b1);
    line_ready = 1'b0;

    // byte merge within one word
    drive_write(32'h104, 4'h3, 32'h11112222);
    @(negedge clk);
    drive_write(32'h104, 4'hC, 32'h33334444);
    @(negedge clk);
    p_req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check_val("t2_valid", line_valid, 1'b1);
    check_val("t2_word1", line_data[63:32], 32'h33332222);
    check_val("t2_data", line_data, {64'h0, 32'h33332222, 32'h0});
    check_val("t2_strb", line_strb, 16'h00F0);
    flush = 1'b0;
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;

    // full line drains without flush
    for (int k = 0; k < 4; k++) begin
      drive_write(32'h200 + 32'(4*k), 4'hF, 32'h10000000 + 32'(k));
      @(negedge clk);
      if (k < 3) check_val("t3_not_yet", line_valid, 1'b0);
    end
    p_req_valid = 1'b0;
    check_val("t3_valid", line_valid, 1'b1);
    check_val("t3_strb", line_strb, 16'hFFFF);
    check_val("t3_addr", line_addr, 32'h200);
    check_val("t3_data", line_data, {32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000});
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;

    // miss with backpressure
    drive_write(32'h100, 4'hF, 32'hD00DF00D);
    @(negedge clk);
    drive_write(32'h300, 4'hF, 32'h12345678);
    #1;
    check_val("t4_miss_ready", p_req_ready, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val("t4_hold_ready", p_req_ready, 1'b0);
      check_val("t4_hold_valid", line_valid, 1'b1);
      check_val("t4_hold_addr", line_addr, 32'h100);
      check_val("t4_hold_strb", line_strb, 16'h000F);
      check_val("t4_hold_data", line_data, {96'h0, 32'hD00DF00D});
      @(negedge clk);
    end
    line_ready = 1'b1;
    @(negedge clk);
    check_val("t4_hs_empty", buf_empty, 1'b1);
    check_val("t4_hs_valid", line_valid, 1'b0);
    check_val("t4_new_ready", p_req_ready, 1'b1);
    line_ready = 1'b0;
    @(negedge clk);
    check_val("t4_new_accepted", buf_empty, 1'b0);
    p_req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check_val("t4_new_valid", line_valid, 1'b1);
    check_val("t4_new_addr", line_addr, 32'h300);
    check_val("t4_new_strb", line_strb, 16'h000F);
    check_val("t4_new_data", line_data, {96'h0, 32'h12345678});
    flush = 1'b0;
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;

    // idle timeout: TIMEOUT=8 drains 8 cycles after the write, TIMEOUT=0 never
    p_addr   = 32'h400;
    p_w_en   = 4'hF;
    p_wdata  = 32'hCAFEF00D;
    valid_t8 = 1'b1;
    valid_t0 = 1'b1;
    @(negedge clk);
    valid_t8 = 1'b0;
    valid_t0 = 1'b0;
    check_val("t5_t8_loaded", empty_t8, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k <= 8) check_val("t5_t8_valid", lv_t8, 1'(k == 8));
      check_val("t5_t0_valid", lv_t0, 1'b0);
    end
    check_val("t5_t8_addr", addr_t8, 32'h400);
    check_val("t5_t8_strb", strb_t8, 16'h000F);
    check_val("t5_t0_busy", empty_t0, 1'b0);
    line_ready = 1'b1;
    @(negedge clk);
    check_val("t5_t8_done", empty_t8, 1'b1);
    line_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check_val("t5_t0_flush", lv_t0, 1'b1);
    flush = 1'b0;
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;

    // randomized traffic against the model
    m_busy = 1'b0;
    m_out  = 1'b0;
    m_tag  = 0;
    m_idle = 0;
    model_clear();
    hold = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_val("r_valid", line_valid, m_out);
      check_val("r_empty", buf_empty, !m_busy);
      if (m_out) begin
        check_val("r_addr", line_addr, 32'(m_tag << 4));
        check_val("r_strb", line_strb, model_strb());
        check_val("r_data", line_data, model_data());
      end
      quiet = ((cyc / 250) % 2) == 1;
      if (!hold) begin
        p_req_valid = quiet ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 3) != 0);
        p_addr  = 32'($urandom_range(1, 3) * 256 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
        p_w_en  = ($urandom_range(0, 4) == 0) ? 4'h0 :
                  ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        p_wdata = $urandom;
      end
      flush      = !quiet && ($urandom_range(0, 15) == 0);
      line_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = model_ready();
      check_val("r_ready", p_req_ready, exp_rdy);
      hold = p_req_valid && !exp_rdy;
      model_step(exp_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
